tx_lane_mapper_pipe: RTL and testbench

Parametrised, registered successor to the combinational DAC-to-lane mapper. Accepts a wide multi-DAC sample word over a valid/ready handshake and buffers it in a 2-entry FIFO. Emits one lane word per transmit-link request (tx_ready) in either byte-split or sample-packed lane order. Adds per-DAC mute, idle insertion on underflow, a saturating underflow counter and registered ILA taps. Sits between the DMA/sample-source stream and the JESD TX core.

---
 rtl/tx_lane_mapper_pipe_if.sv | 25 ++
 rtl/tx_lane_mapper_pipe.sv | 134 +++++++++++++
 tb/tb_tx_lane_mapper_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_lane_mapper_pipe_if.sv
// Stream-side and link-side handshake bundle for tx_lane_mapper_pipe.
// The slave modport is the mapper's view; master is the driving environment.
interface tx_lane_mapper_pipe_if #(
  parameter int NUM_DAC = 4,
  parameter int SPC     = 4
);
  localparam int DW = NUM_DAC * SPC * 16;

  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          tx_ready;
  logic [DW-1:0] m_lane_data;
  logic          m_lane_valid;

  modport master (
    output s_tdata, s_tvalid, tx_ready,
    input  s_tready, m_lane_data, m_lane_valid
  );

  modport slave (
    input  s_tdata, s_tvalid, tx_ready,
    output s_tready, m_lane_data, m_lane_valid
  );
endinterface

// File: rtl/tx_lane_mapper_pipe.sv
// Buffers multi-DAC sample words in a 2-entry FIFO and emits one lane word per
// link request, in byte-split or sample-packed order, with mute and idle fill.
module tx_lane_mapper_pipe #(
  parameter int          NUM_DAC   = 4,
  parameter int          SPC       = 4,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  tx_lane_mapper_pipe_if.slave   bus,
  input  logic                   mode,
  input  logic [NUM_DAC-1:0]     mute,
  input  logic                   cnt_clr,
  output logic                   underflow,
  output logic [31:0]            underflow_cnt,
  output logic [NUM_DAC*16-1:0]  dac_s0_ila
);

  localparam int DW     = NUM_DAC * SPC * 16;
  localparam int LANE_W = SPC * 8;
  localparam int DAC_W  = SPC * 16;

  // Replaces masked DACs with IDLE_WORD, then places samples into lane order.
  function automatic logic [DW-1:0] map_word(input logic [DW-1:0]      w,
                                             input logic [NUM_DAC-1:0] mask,
                                             input logic               packed_mode);
    logic [DW-1:0] o;
    logic [15:0]   smp;
    o = '0;
    for (int d = 0; d < NUM_DAC; d++) begin
      for (int s = 0; s < SPC; s++) begin
        smp = mask[d] ? IDLE_WORD : w[(NUM_DAC-1-d)*DAC_W + s*16 +: 16];
        if (packed_mode) begin
          if (s < SPC/2) o[2*d*LANE_W + s*16 +: 16]                = smp;
          else           o[(2*d+1)*LANE_W + (s-SPC/2)*16 +: 16]    = smp;
        end else begin
          o[2*d*LANE_W + s*8 +: 8]     = smp[15:8];
          o[(2*d+1)*LANE_W + s*8 +: 8] = smp[7:0];
        end
      end
    end
    return o;
  endfunction

  function automatic logic [NUM_DAC*16-1:0] sample0_taps(input logic [DW-1:0]      w,
                                                         input logic [NUM_DAC-1:0] mask);
    logic [NUM_DAC*16-1:0] t;
    t = '0;
    for (int d = 0; d < NUM_DAC; d++)
      t[d*16 +: 16] = mask[d] ? IDLE_WORD : w[(NUM_DAC-1-d)*DAC_W +: 16];
    return t;
  endfunction

  logic [DW-1:0]         mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count, count_nxt;
  logic                  s_tready_q;
  logic                  active_mode;
  logic                  armed;
  logic [DW-1:0]         lane_q;
  logic                  lane_valid_q;
  logic                  underflow_q;
  logic [31:0]           underflow_cnt_q;
  logic [NUM_DAC*16-1:0] ila_q;

  logic                  empty, wr, rd;
  logic [NUM_DAC-1:0]    out_mask;
  logic [DW-1:0]         head;

  assign empty     = (count == 2'd0);
  assign wr        = bus.s_tvalid && s_tready_q;
  assign rd        = bus.tx_ready && !empty;
  assign count_nxt = count + {1'b0, wr} - {1'b0, rd};
  assign head      = mem[rd_ptr];
  // An empty FIFO reuses the mute path with every DAC masked to build the idle word.
  assign out_mask  = empty ? '1 : mute;

  // NOTE: FIFO storage carries no reset; the pointers and count alone define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.s_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count           <= 2'd0;
      s_tready_q      <= 1'b0;
      active_mode     <= 1'b0;
      armed           <= 1'b0;
      lane_q          <= map_word('0, '1, 1'b0);
      lane_valid_q    <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
      ila_q           <= '0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      // NOTE: ready is a register derived from the next fill level, so it never
      // depends combinationally on tx_ready.
      s_tready_q <= (count_nxt != 2'd2);

      if (empty && !wr) active_mode <= mode;

      if (bus.tx_ready) begin
        lane_q       <= map_word(head, out_mask, active_mode);
        lane_valid_q <= !empty;
        ila_q        <= sample0_taps(head, out_mask);
      end

      if (cnt_clr) begin
        armed           <= 1'b0;
        underflow_q     <= 1'b0;
        underflow_cnt_q <= '0;
      end else begin
        if (wr) armed <= 1'b1;
        if (bus.tx_ready && empty && armed) begin
          underflow_q <= 1'b1;
          if (underflow_cnt_q != '1) underflow_cnt_q <= underflow_cnt_q + 32'd1;
        end
      end
    end
  end

  assign bus.s_tready     = s_tready_q;
  assign bus.m_lane_data  = lane_q;
  assign bus.m_lane_valid = lane_valid_q;
  assign underflow        = underflow_q;
  assign underflow_cnt    = underflow_cnt_q;
  assign dac_s0_ila       = ila_q;

endmodule

// File: tb/tb_tx_lane_mapper_pipe.sv
// Directed bench for tx_lane_mapper_pipe with NUM_DAC=4, SPC=4 and hand-mapped
// expected lane words.
module tb_tx_lane_mapper_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [3:0]  mute = 4'b0;
  logic        cnt_clr = 1'b0;
  logic        underflow;
  logic [31:0] underflow_cnt;
  logic [63:0] dac_s0_ila;

  int errors = 0;
  int checks = 0;

  tx_lane_mapper_pipe_if #(.NUM_DAC(4), .SPC(4)) bus();

  tx_lane_mapper_pipe #(.NUM_DAC(4), .SPC(4), .IDLE_WORD(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mode          (mode),
    .mute          (mute),
    .cnt_clr       (cnt_clr),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt),
    .dac_s0_ila    (dac_s0_ila)
  );

  always #5 clk = ~clk;

  // DAC0 only: samples 1122,3344,5566,7788.
  localparam logic [255:0] W1 = {16'h7788, 16'h5566, 16'h3344, 16'h1122, 192'h0};
  localparam logic [255:0] E1_BS = {192'h0, 32'h88664422, 32'h77553311};
  localparam logic [255:0] E1_SP = {192'h0, 32'h77885566, 32'h33441122};

  // All four DACs populated (DAC0 in the top 64 bits).
  localparam logic [255:0] W5 = {16'h7788, 16'h5566, 16'h3344, 16'h1122,
                                 16'hD1D2, 16'hC1C2, 16'hB1B2, 16'hA1A2,
                                 16'h0708, 16'h0506, 16'h0304, 16'h0102,
                                 16'hC0C1, 16'hD0D1, 16'hE0E1, 16'hF0F1};
  localparam logic [255:0] E5 = {32'hC1D1E1F1, 32'hC0D0E0F0, 32'h08060402, 32'h07050301,
                                 32'hD2C2B2A2, 32'hD1C1B1A1, 32'h88664422, 32'h77553311};
  localparam logic [255:0] E5_MUTE2 = {32'hC1D1E1F1, 32'hC0D0E0F0, 32'h00000000, 32'h00000000,
                                       32'hD2C2B2A2, 32'hD1C1B1A1, 32'h88664422, 32'h77553311};
  localparam logic [63:0] ILA5       = {16'hF0F1, 16'h0102, 16'hA1A2, 16'h1122};
  localparam logic [63:0] ILA5_MUTE2 = {16'hF0F1, 16'h0000, 16'hA1A2, 16'h1122};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [255:0] w);
    bit accepted = 1'b0;
    bus.s_tdata  = w;
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (bus.s_tready) accepted = 1'b1;
      tick();
    end
    bus.s_tvalid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL send_word: s_tready never rose within 20 cycles");
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", bus.s_tready); end
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.m_lane_valid); end
    checks++; if (bus.m_lane_data !== 256'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.m_lane_data); end
    checks++; if (underflow !== 1'b0 || underflow_cnt !== 32'd0) begin errors++; $display("FAIL reset_underflow: got %b/%0d want 0/0", underflow, underflow_cnt); end
    checks++; if (dac_s0_ila !== 64'h0) begin errors++; $display("FAIL reset_ila: got %h want 0", dac_s0_ila); end
    rst = 1'b0;
    tick();
    checks++; if (bus.s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready: got %b want 1", bus.s_tready); end
    // Idle requests before any word is accepted must not count.
    bus.tx_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (underflow !== 1'b0 || underflow_cnt !== 32'd0) begin errors++; $display("FAIL unarmed_count: got %b/%0d want 0/0", underflow, underflow_cnt); end
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL unarmed_valid: got %b want 0", bus.m_lane_valid); end
  endtask

  task automatic test_byte_split();
    mode = 1'b0;
    bus.tx_ready = 1'b1;
    send_word(W1);
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL bs_latency: valid got %b want 0 at N+1", bus.m_lane_valid); end
    tick();
    checks++; if (bus.m_lane_data !== E1_BS) begin errors++; $display("FAIL bs_data: got %h want %h", bus.m_lane_data, E1_BS); end
    checks++; if (bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL bs_valid: got %b want 1", bus.m_lane_valid); end
    checks++; if (dac_s0_ila[15:0] !== 16'h1122) begin errors++; $display("FAIL bs_ila: got %h want 1122", dac_s0_ila[15:0]); end
    tick();
    checks++; if (bus.m_lane_valid !== 1'b0 || bus.m_lane_data !== 256'h0) begin errors++; $display("FAIL bs_idle: valid %b data %h want 0/0", bus.m_lane_valid, bus.m_lane_data); end
  endtask

  task automatic test_sample_packed();
    mode = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    send_word(W1);
    tick();
    checks++; if (bus.m_lane_data !== E1_SP) begin errors++; $display("FAIL sp_data: got %h want %h", bus.m_lane_data, E1_SP); end
    checks++; if (bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL sp_valid: got %b want 1", bus.m_lane_valid); end
    mode = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.tx_ready = 1'b0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = W1;
    tick();
    bus.s_tdata  = W5;
    tick();
    bus.s_tdata  = 256'hDEAD;
    checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL b2b_full: s_tready got %b want 0", bus.s_tready); end
    tick(); tick();
    checks++; if (bus.s_tready !== 1'b0 || bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold: s_tready %b valid %b want 0/0", bus.s_tready, bus.m_lane_valid); end
    bus.tx_ready = 1'b1;
    tick();
    bus.s_tvalid = 1'b0;
    checks++; if (bus.m_lane_data !== E1_BS || bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b want %h/1", bus.m_lane_data, bus.m_lane_valid, E1_BS); end
    checks++; if (bus.s_tready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", bus.s_tready); end
    tick();
    checks++; if (bus.m_lane_data !== E5 || bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b want %h/1", bus.m_lane_data, bus.m_lane_valid, E5); end
    tick();
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL b2b_third: valid got %b want 0", bus.m_lane_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_underflow();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (underflow !== 1'b0 || underflow_cnt !== 32'd0) begin errors++; $display("FAIL uf_clear0: got %b/%0d want 0/0", underflow, underflow_cnt); end
    bus.tx_ready = 1'b1;
    tick(); tick();
    checks++; if (underflow_cnt !== 32'd0) begin errors++; $display("FAIL uf_disarmed: got %0d want 0", underflow_cnt); end
    send_word(W1);
    tick();
    checks++; if (bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL uf_word: valid got %b want 1", bus.m_lane_valid); end
    for (int i = 0; i < 5; i++) tick();
    bus.tx_ready = 1'b0;
    checks++; if (underflow_cnt !== 32'd5) begin errors++; $display("FAIL uf_count: got %0d want 5", underflow_cnt); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b want 1", underflow); end
    checks++; if (bus.m_lane_valid !== 1'b0 || bus.m_lane_data !== 256'h0) begin errors++; $display("FAIL uf_idle: %b/%h want 0/0", bus.m_lane_valid, bus.m_lane_data); end
    tick(); tick();
    checks++; if (underflow_cnt !== 32'd5) begin errors++; $display("FAIL uf_hold: got %0d want 5", underflow_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (underflow !== 1'b0 || underflow_cnt !== 32'd0) begin errors++; $display("FAIL uf_clear: got %b/%0d want 0/0", underflow, underflow_cnt); end
  endtask

  task automatic test_mute();
    bus.tx_ready = 1'b0;
    send_word(W5);
    send_word(W5);
    mute = 4'b0100;
    bus.tx_ready = 1'b1;
    tick();
    mute = 4'b0000;
    checks++; if (bus.m_lane_data !== E5_MUTE2) begin errors++; $display("FAIL mute_data: got %h want %h", bus.m_lane_data, E5_MUTE2); end
    checks++; if (dac_s0_ila !== ILA5_MUTE2) begin errors++; $display("FAIL mute_ila: got %h want %h", dac_s0_ila, ILA5_MUTE2); end
    tick();
    checks++; if (bus.m_lane_data !== E5) begin errors++; $display("FAIL unmute_data: got %h want %h", bus.m_lane_data, E5); end
    checks++; if (dac_s0_ila !== ILA5) begin errors++; $display("FAIL unmute_ila: got %h want %h", dac_s0_ila, ILA5); end
    bus.tx_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    send_word(W5);
    send_word(W1);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = W5;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s_tvalid = 1'b0;
    checks++; if (bus.m_lane_valid !== 1'b0 || bus.m_lane_data !== 256'h0) begin errors++; $display("FAIL rmid_out: %b/%h want 0/0", bus.m_lane_valid, bus.m_lane_data); end
    checks++; if (bus.s_tready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", bus.s_tready); end
    tick();
    checks++; if (bus.s_tready !== 1'b1 || bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL rmid_empty: ready %b valid %b want 1/0", bus.s_tready, bus.m_lane_valid); end
    tick();
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale: valid got %b want 0", bus.m_lane_valid); end
    send_word(W5);
    tick();
    checks++; if (bus.m_lane_data !== E5 || bus.m_lane_valid !== 1'b1) begin errors++; $display("FAIL rmid_word: got %h/%b want %h/1", bus.m_lane_data, bus.m_lane_valid, E5); end
    tick();
    checks++; if (bus.m_lane_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain: valid got %b want 0", bus.m_lane_valid); end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_byte_split();
    test_sample_packed();
    test_back_to_back();
    test_underflow();
    test_mute();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
